// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
// Purpose : Groups the three core-side memory ports (fetch, data read, data
//           write) and the external single-port memory bus into one bundle.
// Signals : ia/ia_enable -> iv/iv_valid                 instruction fetch
//           da_in/da_in_enable -> dv_in/dv_in_valid     data read
//           da_out/dv_out/da_out_enable -> dv_out_valid data write
//           mem_address/mem_request/mem_write/mem_wdata -> mem_rdata/mem_ack
// Modports: master - the arbiter (drives results and the memory bus)
//           slave  - the surroundings (core ports plus the memory itself)
// -----------------------------------------------------------------------------
interface memory_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] ia;
  logic             ia_enable;
  logic [WIDTH-1:0] iv;
  logic             iv_valid;

  logic [WIDTH-1:0] da_in;
  logic             da_in_enable;
  logic [WIDTH-1:0] dv_in;
  logic             dv_in_valid;

  logic [WIDTH-1:0] da_out;
  logic             da_out_enable;
  logic [WIDTH-1:0] dv_out;
  logic             dv_out_valid;

  logic [WIDTH-1:0] mem_address;
  logic             mem_request;
  logic             mem_write;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    input  ia, ia_enable, da_in, da_in_enable, da_out, da_out_enable, dv_out,
           mem_rdata, mem_ack,
    output iv, iv_valid, dv_in, dv_in_valid, dv_out_valid,
           mem_address, mem_request, mem_write, mem_wdata
  );

  modport slave (
    output ia, ia_enable, da_in, da_in_enable, da_out, da_out_enable, dv_out,
           mem_rdata, mem_ack,
    input  iv, iv_valid, dv_in, dv_in_valid, dv_out_valid,
           mem_address, mem_request, mem_write, mem_wdata
  );
endinterface

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Purpose : Merges the core's fetch, data-read and data-write ports onto one
//           external single-port memory bus, one transaction at a time.
//           Each transaction runs IDLE -> ISSUE -> DONE; the requesting port
//           sees a one-cycle valid pulse in DONE.
// Ports   : clock - rising-edge clock
//           reset - synchronous, active-high
//           bus   - memory_arbiter_if.master (core ports and memory bus)
// Config  : MEMORY_ARBITER_ROUND_ROBIN_EN
//             undefined: fixed priority write > read > fetch
//             defined  : rotating priority fetch -> read -> write, search
//                        starting at a pointer that moves past each grant
// Note    : WIDTH must match the WIDTH of the connected interface instance.
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  memory_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Grant encoding; G_NONE doubles as "no request" from the selector.
  localparam logic [1:0] G_NONE  = 2'd0;
  localparam logic [1:0] G_FETCH = 2'd1;
  localparam logic [1:0] G_READ  = 2'd2;
  localparam logic [1:0] G_WRITE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       grant;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             write_q;
  logic [WIDTH-1:0] iv_q;
  logic [WIDTH-1:0] dv_in_q;

  logic [1:0]       pick;
  logic [WIDTH-1:0] next_addr;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // Pointer is a port index: 0 = fetch, 1 = read, 2 = write.
  logic [1:0] rr_ptr;
  logic [1:0] next_ptr;

  // NOTE: every always_comb output gets a default before any branch so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pick = G_NONE;
    unique case (rr_ptr)
      2'd0: begin
        if (bus.ia_enable)          pick = G_FETCH;
        else if (bus.da_in_enable)  pick = G_READ;
        else if (bus.da_out_enable) pick = G_WRITE;
      end
      2'd1: begin
        if (bus.da_in_enable)       pick = G_READ;
        else if (bus.da_out_enable) pick = G_WRITE;
        else if (bus.ia_enable)     pick = G_FETCH;
      end
      default: begin
        if (bus.da_out_enable)      pick = G_WRITE;
        else if (bus.ia_enable)     pick = G_FETCH;
        else if (bus.da_in_enable)  pick = G_READ;
      end
    endcase
  end

  // Pointer moves to the port after the granted one. With this grant
  // encoding that is the grant code itself, except write wraps to fetch.
  assign next_ptr = (pick == G_WRITE) ? 2'd0 : pick;
`else
  // NOTE: every always_comb output gets a default before any branch so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pick = G_NONE;
    if (bus.da_out_enable)      pick = G_WRITE;
    else if (bus.da_in_enable)  pick = G_READ;
    else if (bus.ia_enable)     pick = G_FETCH;
  end
`endif

  always_comb begin
    next_addr = bus.ia;
    unique case (pick)
      G_READ:  next_addr = bus.da_in;
      G_WRITE: next_addr = bus.da_out;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      grant   <= G_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      iv_q    <= '0;
      dv_in_q <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      rr_ptr  <= 2'd0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick != G_NONE) begin
            // Everything the bus needs is captured here so later changes on
            // the requesting port cannot disturb the transaction.
            grant   <= pick;
            addr_q  <= next_addr;
            wdata_q <= bus.dv_out;
            write_q <= (pick == G_WRITE);
            state   <= S_ISSUE;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            rr_ptr  <= next_ptr;
`endif
          end
        end
        S_ISSUE: begin
          // ack is only honoured here; in IDLE/DONE it is ignored.
          if (bus.mem_ack) begin
            if (grant == G_FETCH) iv_q    <= bus.mem_rdata;
            if (grant == G_READ)  dv_in_q <= bus.mem_rdata;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          grant <= G_NONE;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state, so a valid pulse and
  // mem_request can never coincide (DONE vs ISSUE).
  assign bus.mem_request  = (state == S_ISSUE);
  assign bus.mem_write    = write_q & bus.mem_request;
  assign bus.mem_address  = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.iv           = iv_q;
  assign bus.dv_in        = dv_in_q;
  assign bus.iv_valid     = (state == S_DONE) && (grant == G_FETCH);
  assign bus.dv_in_valid  = (state == S_DONE) && (grant == G_READ);
  assign bus.dv_out_valid = (state == S_DONE) && (grant == G_WRITE);

endmodule
